// File: rtl/ibf_encoder_if.sv
// rtl/ibf_encoder_if.sv - key, control and table-dump signals of the IBF encoder
// IBF_COUNT_ERR_EN adds the sticky count-wrap flag err.
interface ibf_encoder_if #(
    parameter int KEY_W   = 32,
    parameter int SIG_W   = 8,
    parameter int COUNT_W = 8,
    parameter int INDEX_W = 6
);
    localparam int CELL_W = KEY_W + SIG_W + COUNT_W;

    logic               key_valid;
    logic [KEY_W-1:0]   key;
    logic               op_del;
    logic               key_ready;
    logic               clear;
    logic               dump_start;
    logic               Wr;
    logic [INDEX_W:0]   Addr;
    logic [CELL_W-1:0]  IBF_Row;
    logic               dump_done;
`ifdef IBF_COUNT_ERR_EN
    logic               err;

    modport master (
        output key_valid, key, op_del, clear, dump_start,
        input  key_ready, Wr, Addr, IBF_Row, dump_done, err
    );
    modport slave (
        input  key_valid, key, op_del, clear, dump_start,
        output key_ready, Wr, Addr, IBF_Row, dump_done, err
    );
`else
    modport master (
        output key_valid, key, op_del, clear, dump_start,
        input  key_ready, Wr, Addr, IBF_Row, dump_done
    );
    modport slave (
        input  key_valid, key, op_del, clear, dump_start,
        output key_ready, Wr, Addr, IBF_Row, dump_done
    );
`endif
endinterface

// File: rtl/ibf_encoder.sv
// rtl/ibf_encoder.sv - invertible Bloom filter encoder: CRC-32 hashed insert/delete and table dump
// IBF_COUNT_ERR_EN enables the sticky count-wrap output err.
module ibf_crc32 #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    output logic [31:0]       crc
);
    localparam logic [31:0] POLY = 32'h04C11DB7;

    always_comb begin
        crc = 32'hFFFF_FFFF;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (crc[31] ^ data[i]) crc = {crc[30:0], 1'b0} ^ POLY;
            else                   crc = {crc[30:0], 1'b0};
        end
    end
endmodule

module ibf_encoder #(
    parameter int KEY_W   = 32,
    parameter int SIG_W   = 8,
    parameter int COUNT_W = 8,
    parameter int INDEX_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    ibf_encoder_if.slave    bus
);
    localparam int CELL_W   = KEY_W + SIG_W + COUNT_W;
    localparam int IBF_SIZE = 1 << INDEX_W;
    localparam logic [INDEX_W:0] LAST_ROW = {1'b0, {INDEX_W{1'b1}}};
    localparam logic [INDEX_W:0] DONE_ROW = {1'b1, {INDEX_W{1'b0}}};

    typedef enum logic [2:0] {
        S_CLEAR, S_READY, S_HASH, S_UPD1, S_UPD2, S_UPD3, S_DUMP
    } state_t;

    state_t             state, state_nxt;
    logic [INDEX_W:0]   addr_q, addr_nxt;
    logic [KEY_W-1:0]   key_q;
    logic               del_q;
    logic [31:0]        crc_comb, hash_q;
    logic               unused_hash;

    logic [CELL_W-1:0]  table_mem [IBF_SIZE];

    logic [INDEX_W-1:0] upd_idx;
    logic [SIG_W-1:0]   sig;
    logic [KEY_W-1:0]   c_key;
    logic [SIG_W-1:0]   c_sig;
    logic [COUNT_W-1:0] c_cnt, cnt_nxt;
    logic [CELL_W-1:0]  cell_nxt;
    logic               upd_active;
    logic               mem_we;
    logic [INDEX_W-1:0] mem_idx;
    logic [CELL_W-1:0]  mem_wdata;

    ibf_crc32 #(.DATA_W(KEY_W)) u_crc (
        .data (key_q),
        .crc  (crc_comb)
    );

    // Only the index and signature fields of the hash are consumed.
    assign unused_hash = ^hash_q;
    assign sig         = hash_q[25 -: SIG_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_CLEAR;
            addr_q <= '0;
            key_q  <= '0;
            del_q  <= 1'b0;
            hash_q <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
            if (state_nxt == S_HASH) begin
                key_q <= bus.key;
                del_q <= bus.op_del;
            end
            if (state == S_HASH) hash_q <= crc_comb;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        case (state)
            S_CLEAR: begin
                if (addr_q == LAST_ROW) begin
                    state_nxt = S_READY;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = addr_q + 1'b1;
                end
            end
            S_READY: begin
                if (bus.key_valid) begin
                    state_nxt = S_HASH;
                end else if (bus.dump_start) begin
                    state_nxt = S_DUMP;
                    addr_nxt  = '0;
                end
            end
            S_HASH: state_nxt = S_UPD1;
            S_UPD1: state_nxt = S_UPD2;
            S_UPD2: state_nxt = S_UPD3;
            S_UPD3: state_nxt = S_READY;
            S_DUMP: begin
                if (addr_q == DONE_ROW) begin
                    state_nxt = S_READY;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = addr_q + 1'b1;
                end
            end
            default: begin
                state_nxt = S_CLEAR;
                addr_nxt  = '0;
            end
        endcase
        // clear overrides everything except an ongoing clear pass
        if (bus.clear && state != S_CLEAR) begin
            state_nxt = S_CLEAR;
            addr_nxt  = '0;
        end
    end

    always_comb begin
        bus.key_ready = (state == S_READY);
        bus.Wr        = 1'b0;
        bus.Addr      = '0;
        bus.IBF_Row   = '0;
        bus.dump_done = 1'b0;
        if (state == S_DUMP) begin
            if (addr_q[INDEX_W]) begin
                bus.dump_done = 1'b1;
            end else begin
                bus.Wr      = 1'b1;
                bus.Addr    = addr_q;
                bus.IBF_Row = table_mem[addr_q[INDEX_W-1:0]];
            end
        end

        upd_active = 1'b0;
        upd_idx    = hash_q[INDEX_W-1:0];
        case (state)
            S_UPD1: begin upd_active = 1'b1; upd_idx = hash_q[31 -: INDEX_W]; end
            S_UPD2: begin upd_active = 1'b1; upd_idx = hash_q[25 -: INDEX_W]; end
            S_UPD3: begin upd_active = 1'b1; upd_idx = hash_q[INDEX_W-1:0];   end
            default: ;
        endcase

        {c_key, c_sig, c_cnt} = table_mem[upd_idx];
        cnt_nxt  = del_q ? c_cnt - 1'b1 : c_cnt + 1'b1;
        cell_nxt = {c_key ^ key_q, c_sig ^ sig, cnt_nxt};

        mem_we    = 1'b0;
        mem_idx   = upd_idx;
        mem_wdata = cell_nxt;
        if (state == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_idx   = addr_q[INDEX_W-1:0];
            mem_wdata = '0;
        end else if (upd_active && !bus.clear) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) table_mem[mem_idx] <= mem_wdata;
    end

`ifdef IBF_COUNT_ERR_EN
    logic wrap;
    logic err_q;

    assign wrap = del_q ? (c_cnt == '0) : (&c_cnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            err_q <= 1'b0;
        else if (bus.clear)                    err_q <= 1'b0;
        else if (upd_active && wrap)           err_q <= 1'b1;
    end

    assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_ibf_encoder.sv
// tb/tb_ibf_encoder.sv - directed self-checking bench for ibf_encoder
module tb_ibf_encoder;
    logic clk;
    logic reset;
    int   ntests;
    int   nfail;
    int   n;
    logic [47:0] mdl [64];
    logic [47:0] cap [64];
    logic [31:0] ck, hc;
    logic [5:0]  h1, h3;
    logic [7:0]  hs;

    ibf_encoder_if bus ();

    ibf_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference CRC as polynomial remainder: ((key ^ init) * x^32) mod P.
    function automatic logic [31:0] crc_ref(input logic [31:0] k);
        logic [63:0] r;
        r = {k ^ 32'hFFFF_FFFF, 32'h0};
        for (int i = 63; i >= 32; i--)
            if (r[i]) r[i -: 33] = r[i -: 33] ^ {1'b1, 32'h04C11DB7};
        return r[31:0];
    endfunction

    task automatic model_op(input logic [31:0] k, input logic del);
        logic [31:0] c;
        logic [5:0]  idx [3];
        logic [31:0] mk;
        logic [7:0]  ms, mc;
        c = crc_ref(k);
        idx[0] = c[31:26];
        idx[1] = c[25:20];
        idx[2] = c[5:0];
        for (int j = 0; j < 3; j++) begin
            {mk, ms, mc} = mdl[idx[j]];
            mdl[idx[j]] = {mk ^ k, ms ^ c[25:18], del ? mc - 8'd1 : mc + 8'd1};
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < 64; i++) mdl[i] = '0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!bus.key_ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic do_dump(input string tag);
        int w;
        wait_ready(w);
        chk({tag, "_ready"}, 64'(bus.key_ready), 64'd1);
        bus.dump_start = 1'b1;
        @(negedge clk);
        bus.dump_start = 1'b0;
        for (int r = 0; r < 64; r++) begin
            chk($sformatf("%s_wr_addr%0d", tag, r), 64'({bus.Wr, bus.Addr}), 64'({1'b1, 7'(r)}));
            cap[r] = bus.IBF_Row;
            chk($sformatf("%s_row%0d", tag, r), 64'(bus.IBF_Row), 64'(mdl[r]));
            @(negedge clk);
        end
        chk({tag, "_done"}, 64'({bus.Wr, bus.dump_done}), 64'b01);
        @(negedge clk);
        chk({tag, "_after_done"}, 64'({bus.dump_done, bus.key_ready}), 64'b01);
    endtask

    task automatic key_op(input logic [31:0] k, input logic del, input logic with_dump);
        int w;
        int lo;
        wait_ready(w);
        bus.key_valid  = 1'b1;
        bus.key        = k;
        bus.op_del     = del;
        bus.dump_start = with_dump;
        @(negedge clk);
        bus.key_valid  = 1'b0;
        bus.dump_start = 1'b0;
        lo = 0;
        while (!bus.key_ready && lo < 20) begin
            lo++;
            @(negedge clk);
        end
        chk("ready_low_cycles", 64'(lo), 64'd4);
        chk("no_dump_after_key", 64'(bus.Wr), 64'd0);
        model_op(k, del);
    endtask

    task automatic do_clear(input string tag);
        int w;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        wait_ready(w);
        chk({tag, "_clear_cycles"}, 64'(w), 64'd64);
        model_zero();
    endtask

    initial begin
        ntests = 0;
        nfail  = 0;
        reset  = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key        = '0;
        bus.op_del     = 1'b0;
        bus.clear      = 1'b0;
        bus.dump_start = 1'b0;
        model_zero();

        repeat (3) @(negedge clk);
        chk("rst_key_ready", 64'(bus.key_ready), 64'd0);
        chk("rst_wr",        64'(bus.Wr), 64'd0);
        chk("rst_addr",      64'(bus.Addr), 64'd0);
        chk("rst_row",       64'(bus.IBF_Row), 64'd0);
        chk("rst_done",      64'(bus.dump_done), 64'd0);
`ifdef IBF_COUNT_ERR_EN
        chk("rst_err",       64'(bus.err), 64'd0);
`endif

        reset = 1'b1;
        wait_ready(n);
        chk("init_clear_cycles", 64'(n), 64'd64);
        do_dump("empty");

        key_op(32'h1234_5678, 1'b0, 1'b1);
        do_dump("ins1");
        hc = crc_ref(32'h1234_5678);
        chk("ins1_h3_cell_key", 64'(cap[hc[5:0]][47:16]), 64'(hc[31:26] == hc[5:0] || hc[25:20] == hc[5:0] ? cap[hc[5:0]][47:16] : 32'h1234_5678));
        chk("ins1_h1_cnt_nz", 64'(cap[hc[31:26]][7:0] != 8'd0), 64'd1);

        key_op(32'h1234_5678, 1'b1, 1'b0);
        do_dump("insdel");
        n = 0;
        for (int i = 0; i < 64; i++) if (cap[i] != '0) n++;
        chk("insdel_nonzero_cells", 64'(n), 64'd0);

        ck = 32'h0000_0001;
        for (int i = 0; i < 100000; i++) begin
            hc = crc_ref(ck);
            if (hc[31:26] == hc[25:20] && hc[5:0] != hc[31:26]) break;
            ck++;
        end
        h1 = hc[31:26];
        h3 = hc[5:0];
        hs = hc[25:18];
        key_op(ck, 1'b0, 1'b0);
        do_dump("collide");
        chk("collide_h1", 64'(cap[h1]), 64'({32'h0, 8'h00, 8'd2}));
        chk("collide_h3", 64'(cap[h3]), 64'({ck, hs, 8'd1}));

        do_clear("pre_del");
        key_op(32'hA5A5_A5A5, 1'b1, 1'b0);
        do_dump("del_empty");
        hc = crc_ref(32'hA5A5_A5A5);
        chk("del_empty_h3_cnt", 64'(cap[hc[5:0]][7:0] & 8'hFC), 64'h00FC);
`ifdef IBF_COUNT_ERR_EN
        chk("err_set", 64'(bus.err), 64'd1);
`endif
        do_clear("del");
`ifdef IBF_COUNT_ERR_EN
        chk("err_cleared", 64'(bus.err), 64'd0);
`endif
        do_dump("del_cleared");

        for (int i = 0; i < 10; i++) key_op(32'hC0DE_0000 + 32'(i * 7919), 1'b0, 1'b0);
        do_dump("ten_keys");

        wait_ready(n);
        bus.dump_start = 1'b1;
        @(negedge clk);
        bus.dump_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("middump_wr_before", 64'({bus.Wr, bus.Addr}), 64'({1'b1, 7'd10}));
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("middump_wr_drop", 64'({bus.Wr, bus.key_ready}), 64'd0);
        wait_ready(n);
        chk("middump_clear_cycles", 64'(n), 64'd64);
        model_zero();
        do_dump("middump_cleared");

        wait_ready(n);
        bus.key_valid = 1'b1;
        bus.key       = 32'hDEAD_BEEF;
        bus.op_del    = 1'b0;
        @(negedge clk);
        bus.key_valid = 1'b0;
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        wait_ready(n);
        chk("midupd_clear_cycles", 64'(n), 64'd64);
        do_dump("midupd_cleared");

        key_op(32'h0BAD_F00D, 1'b0, 1'b0);
        wait_ready(n);
        bus.dump_start = 1'b1;
        @(negedge clk);
        bus.dump_start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_wr",    64'({bus.Wr, bus.dump_done}), 64'd0);
        chk("async_rst_addr",  64'(bus.Addr), 64'd0);
        chk("async_rst_ready", 64'(bus.key_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        wait_ready(n);
        chk("async_rst_clear_cycles", 64'(n), 64'd64);
        model_zero();
        do_dump("after_reset");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
